// File: rtl/sprite_sched_pkg.sv
// Shared types and constants for the sprite scheduler: slot descriptor,
// controller state encoding and the span helper used by each slot comparator.
package sprite_sched_pkg;

  localparam int N_SPRITES = 4;
  localparam int V_ACTIVE  = 480;
  localparam int COORD_W   = 10;
  localparam int MULT_W    = 4;
  localparam int ID_W      = (N_SPRITES > 1) ? $clog2(N_SPRITES) : 1;

  // Scaled extent fits in 14 bits and origin + extent in 15, so neither wraps.
  localparam int PROD_W = COORD_W + MULT_W;
  localparam int SUM_W  = PROD_W + 1;

  typedef enum logic [1:0] {
    ST_BLANK  = 2'd0,
    ST_RUN    = 2'd1,
    ST_COMMIT = 2'd2
  } state_t;

  typedef struct packed {
    logic [COORD_W-1:0] x;
    logic [COORD_W-1:0] y;
    logic [COORD_W-1:0] w;
    logic [COORD_W-1:0] h;
    logic [MULT_W-1:0]  mult;
    logic               vis;
  } desc_t;

  // True when origin <= pos < origin + size*mult (half-open span).
  function automatic logic in_span(input logic [COORD_W-1:0] pos,
                                   input logic [COORD_W-1:0] origin,
                                   input logic [COORD_W-1:0] size,
                                   input logic [MULT_W-1:0]  mult);
    logic [PROD_W-1:0] extent;
    logic [SUM_W-1:0]  limit;
    extent = PROD_W'(size) * PROD_W'(mult);
    limit  = SUM_W'(origin) + SUM_W'(extent);
    return (pos >= origin) && (SUM_W'(pos) < limit);
  endfunction

endpackage

// File: rtl/sprite_scheduler_if.sv
// Descriptor update port between game logic (master) and the sprite scheduler
// (slave).
interface sprite_scheduler_if;
  import sprite_sched_pkg::*;

  // Handshake: the master raises upd_req with all upd_* fields and holds them
  // stable until it sees upd_ack high; the write takes effect on that clock
  // edge. upd_ack is combinational and may stay low (commit cycle, reset).
  logic               upd_req;
  logic               upd_ack;
  logic [ID_W-1:0]    upd_id;
  logic [COORD_W-1:0] upd_x;
  logic [COORD_W-1:0] upd_y;
  logic [COORD_W-1:0] upd_w;
  logic [COORD_W-1:0] upd_h;
  logic [MULT_W-1:0]  upd_mult;
  logic               upd_vis;

  modport master (
    output upd_req, upd_id, upd_x, upd_y, upd_w, upd_h, upd_mult, upd_vis,
    input  upd_ack
  );

  modport slave (
    input  upd_req, upd_id, upd_x, upd_y, upd_w, upd_h, upd_mult, upd_vis,
    output upd_ack
  );

endinterface

// File: rtl/sprite_hit_test.sv
// One slot's coverage comparator: decides whether the active descriptor
// covers the current pixel. Degenerate sprites (zero size or scale) never hit.
module sprite_hit_test
  import sprite_sched_pkg::*;
(
  input  desc_t              desc,
  input  logic [COORD_W-1:0] px,
  input  logic [COORD_W-1:0] py,
  output logic               hit
);

  logic non_degenerate;

  assign non_degenerate = desc.vis && (desc.mult != '0) &&
                          (desc.w != '0) && (desc.h != '0);

  assign hit = non_degenerate &&
               in_span(px, desc.x, desc.w, desc.mult) &&
               in_span(py, desc.y, desc.h, desc.mult);

endmodule

// File: rtl/sprite_scheduler.sv
// Per-frame sprite scheduler: shadow descriptor writes, atomic commit at the
// start of vertical blanking, per-pixel fixed-priority ownership. Optional
// SPRITE_SCHED_COLLISION_EN adds a per-frame collision_mask output.
module sprite_scheduler
  import sprite_sched_pkg::*;
(
  input  logic               CLK,
  input  logic               reset,
  input  logic [COORD_W-1:0] X_VGA,
  input  logic [COORD_W-1:0] Y_VGA,
  sprite_scheduler_if.slave  upd,
  output logic [COORD_W-1:0] X_OBJETO,
  output logic [COORD_W-1:0] Y_OBJETO,
  output logic [COORD_W-1:0] LARGURA_OBJETO,
  output logic [COORD_W-1:0] ALTURA_OBJETO,
  output logic [MULT_W-1:0]  MULTPLICADOR,
  output logic [ID_W-1:0]    sel_id,
  output logic               sel_valid,
  output logic               frame_commit,
`ifdef SPRITE_SCHED_COLLISION_EN
  output logic [N_SPRITES-1:0] collision_mask,
`endif
  output state_t             state_dbg
);

  state_t state;
  state_t state_next;

  desc_t shadow [N_SPRITES];
  desc_t active [N_SPRITES];
  desc_t wr_desc;

  logic [N_SPRITES-1:0] hit_vec;
  logic                 any_hit;
  logic [ID_W-1:0]      win_id;
  desc_t                win_desc;

  assign state_dbg = state;

  assign wr_desc = '{x:    upd.upd_x,
                     y:    upd.upd_y,
                     w:    upd.upd_w,
                     h:    upd.upd_h,
                     mult: upd.upd_mult,
                     vis:  upd.upd_vis};

  always_ff @(posedge CLK) begin
    if (!reset) state <= ST_BLANK;
    else        state <= state_next;
  end

  always_comb begin
    state_next   = state;
    upd.upd_ack  = 1'b0;
    frame_commit = 1'b0;
    case (state)
      ST_BLANK: begin
        upd.upd_ack = reset && upd.upd_req;
        if (X_VGA == '0 && Y_VGA == '0) state_next = ST_RUN;
      end
      ST_RUN: begin
        upd.upd_ack = reset && upd.upd_req;
        if (X_VGA == '0 && Y_VGA == COORD_W'(V_ACTIVE)) state_next = ST_COMMIT;
      end
      ST_COMMIT: begin
        frame_commit = reset;
        state_next   = ST_BLANK;
      end
      default: state_next = ST_BLANK;
    endcase
  end

  // Writes to an id with no slot behind it are acked and fall through here.
  always_ff @(posedge CLK) begin
    if (!reset) begin
      for (int i = 0; i < N_SPRITES; i++) begin
        shadow[i] <= '0;
        active[i] <= '0;
      end
    end else begin
      for (int i = 0; i < N_SPRITES; i++) begin
        if (upd.upd_ack && upd.upd_id == ID_W'(i)) shadow[i] <= wr_desc;
        if (state == ST_COMMIT) active[i] <= shadow[i];
      end
    end
  end

  for (genvar g = 0; g < N_SPRITES; g++) begin : g_hit
    sprite_hit_test u_hit (
      .desc (active[g]),
      .px   (X_VGA),
      .py   (Y_VGA),
      .hit  (hit_vec[g])
    );
  end

  // Scan from the lowest priority up so slot 0 is the final override.
  always_comb begin
    any_hit  = 1'b0;
    win_id   = '0;
    win_desc = '0;
    for (int i = N_SPRITES - 1; i >= 0; i--) begin
      if (hit_vec[i]) begin
        any_hit  = 1'b1;
        win_id   = ID_W'(i);
        win_desc = active[i];
      end
    end
  end

  always_ff @(posedge CLK) begin
    if (!reset || state != ST_RUN || !any_hit) begin
      sel_valid      <= 1'b0;
      sel_id         <= '0;
      X_OBJETO       <= '0;
      Y_OBJETO       <= '0;
      LARGURA_OBJETO <= '0;
      ALTURA_OBJETO  <= '0;
      MULTPLICADOR   <= '0;
    end else begin
      sel_valid      <= 1'b1;
      sel_id         <= win_id;
      X_OBJETO       <= win_desc.x;
      Y_OBJETO       <= win_desc.y;
      LARGURA_OBJETO <= win_desc.w;
      ALTURA_OBJETO  <= win_desc.h;
      MULTPLICADOR   <= win_desc.mult;
    end
  end

`ifdef SPRITE_SCHED_COLLISION_EN
  logic [N_SPRITES-1:0] sticky;
  logic                 multi_hit;

  // At least two bits set: clearing the lowest set bit leaves something.
  assign multi_hit = (hit_vec & (hit_vec - N_SPRITES'(1))) != '0;

  always_ff @(posedge CLK) begin
    if (!reset) begin
      sticky         <= '0;
      collision_mask <= '0;
    end else if (state == ST_COMMIT) begin
      collision_mask <= sticky;
      sticky         <= '0;
    end else if (state == ST_RUN && multi_hit) begin
      sticky <= sticky | hit_vec;
    end
  end
`endif

endmodule

// File: tb/tb_sprite_scheduler.sv
// Randomised scoreboard bench for sprite_scheduler against a frame-level
// reference model of descriptors, commits and pixel ownership.
`timescale 1ns/1ps
module tb_sprite_scheduler;
  import sprite_sched_pkg::*;

  localparam int PACK_W = 1 + ID_W + 4*COORD_W + MULT_W + 2 + N_SPRITES;

  typedef struct {
    int x;
    int y;
    int w;
    int h;
    int m;
    int v;
  } spr_t;

  logic               CLK = 1'b0;
  logic               reset;
  logic [COORD_W-1:0] X_VGA, Y_VGA;
  logic [COORD_W-1:0] X_OBJETO, Y_OBJETO, LARGURA_OBJETO, ALTURA_OBJETO;
  logic [MULT_W-1:0]  MULTPLICADOR;
  logic [ID_W-1:0]    sel_id;
  logic               sel_valid;
  logic               frame_commit;
  logic [N_SPRITES-1:0] coll_act;
  state_t             state_dbg;

  sprite_scheduler_if upd ();

`ifdef SPRITE_SCHED_COLLISION_EN
  logic [N_SPRITES-1:0] collision_mask;
  assign coll_act = collision_mask;
`else
  assign coll_act = '0;
`endif

  sprite_scheduler dut (
    .CLK            (CLK),
    .reset          (reset),
    .X_VGA          (X_VGA),
    .Y_VGA          (Y_VGA),
    .upd            (upd),
    .X_OBJETO       (X_OBJETO),
    .Y_OBJETO       (Y_OBJETO),
    .LARGURA_OBJETO (LARGURA_OBJETO),
    .ALTURA_OBJETO  (ALTURA_OBJETO),
    .MULTPLICADOR   (MULTPLICADOR),
    .sel_id         (sel_id),
    .sel_valid      (sel_valid),
    .frame_commit   (frame_commit),
`ifdef SPRITE_SCHED_COLLISION_EN
    .collision_mask (collision_mask),
`endif
    .state_dbg      (state_dbg)
  );

  // ---------------- clock ----------------
  always #5 CLK = ~CLK;

  // ---------------- reference model ----------------
  logic [PACK_W-1:0] exp_q[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  int   m_phase;        // 0 blanking, 1 active picture, 2 commit cycle
  spr_t sh  [N_SPRITES];
  spr_t act [N_SPRITES];
  logic                 e_valid;
  logic [ID_W-1:0]      e_id;
  logic [COORD_W-1:0]   e_x, e_y, e_w, e_h;
  logic [MULT_W-1:0]    e_m;
  logic [N_SPRITES-1:0] e_coll, m_sticky;
  bit   taken;

  function automatic bit covers(input spr_t s, input int px, input int py);
    return s.v != 0 && s.m != 0 && s.w != 0 && s.h != 0 &&
           px >= s.x && px < s.x + s.w * s.m &&
           py >= s.y && py < s.y + s.h * s.m;
  endfunction

  task automatic model_clear();
    m_phase = 0;
    for (int i = 0; i < N_SPRITES; i++) begin
      sh[i]  = '{0, 0, 0, 0, 0, 0};
      act[i] = '{0, 0, 0, 0, 0, 0};
    end
    e_valid = 0; e_id = '0; e_x = '0; e_y = '0; e_w = '0; e_h = '0; e_m = '0;
    e_coll = '0; m_sticky = '0;
  endtask

  // Drive one pixel, queue what the DUT must show before the next edge,
  // then advance the model across that edge.
  task automatic step(input int px, input int py);
    logic exp_ack, exp_commit;
    logic [N_SPRITES-1:0] hits;
    int nh, win;
    X_VGA = COORD_W'(px);
    Y_VGA = COORD_W'(py);
    exp_ack    = reset && upd.upd_req && (m_phase != 2);
    exp_commit = reset && (m_phase == 2);
    exp_q.push_back({e_valid, e_id, e_x, e_y, e_w, e_h, e_m,
                     exp_ack, exp_commit, e_coll});
    if (!reset) begin
      model_clear();
    end else begin
      hits = '0; nh = 0; win = -1;
      for (int i = 0; i < N_SPRITES; i++) begin
        if (covers(act[i], px, py)) begin
          hits[i] = 1'b1;
          nh++;
          if (win < 0) win = i;
        end
      end
      if (m_phase == 1 && win >= 0) begin
        e_valid = 1'b1;
        e_id = ID_W'(win);
        e_x = COORD_W'(act[win].x); e_y = COORD_W'(act[win].y);
        e_w = COORD_W'(act[win].w); e_h = COORD_W'(act[win].h);
        e_m = MULT_W'(act[win].m);
      end else begin
        e_valid = 0; e_id = '0; e_x = '0; e_y = '0; e_w = '0; e_h = '0; e_m = '0;
      end
`ifdef SPRITE_SCHED_COLLISION_EN
      if (m_phase == 2) begin
        e_coll = m_sticky;
        m_sticky = '0;
      end else if (m_phase == 1 && nh >= 2) begin
        m_sticky = m_sticky | hits;
      end
`endif
      if (exp_ack && int'(upd.upd_id) < N_SPRITES)
        sh[upd.upd_id] = '{int'(upd.upd_x), int'(upd.upd_y), int'(upd.upd_w),
                           int'(upd.upd_h), int'(upd.upd_mult), int'(upd.upd_vis)};
      if (m_phase == 2)
        for (int i = 0; i < N_SPRITES; i++) act[i] = sh[i];
      case (m_phase)
        0:       if (px == 0 && py == 0) m_phase = 1;
        1:       if (px == 0 && py == V_ACTIVE) m_phase = 2;
        default: m_phase = 0;
      endcase
    end
    taken = exp_ack;
    @(posedge CLK);
    #2;
    if (taken) upd.upd_req = 1'b0;
  endtask

  // ---------------- driver tasks ----------------
  task automatic post_write(input int id, input int x, input int y, input int w,
                            input int h, input int m, input int v);
    upd.upd_req  = 1'b1;
    upd.upd_id   = ID_W'(id);
    upd.upd_x    = COORD_W'(x);
    upd.upd_y    = COORD_W'(y);
    upd.upd_w    = COORD_W'(w);
    upd.upd_h    = COORD_W'(h);
    upd.upd_mult = MULT_W'(m);
    upd.upd_vis  = v[0];
  endtask

  task automatic write_slot(input int id, input int x, input int y, input int w,
                            input int h, input int m, input int v);
    int budget;
    post_write(id, x, y, w, h, m, v);
    budget = 20;
    do begin
      step(1, 1);
      budget--;
    end while (!taken && budget > 0);
    if (!taken) begin
      n_checks++;
      n_fail++;
      $display("FAIL write_timeout: slot %0d write not accepted within 20 cycles", id);
      upd.upd_req = 1'b0;
    end
  endtask

  task automatic scan(input int y, input int x0, input int x1);
    for (int x = x0; x <= x1; x++) step(x, y);
  endtask

  task automatic frame_start();
    step(0, 0);
  endtask

  task automatic frame_end();
    step(0, V_ACTIVE);
    step(3, V_ACTIVE + 1);
    step(3, V_ACTIVE + 2);
  endtask

  // ---------------- scoreboard monitor ----------------
  always @(negedge CLK) begin
    logic [PACK_W-1:0] exp_v, act_v;
    if (exp_q.size() > 0) begin
      exp_v = exp_q.pop_front();
      act_v = {sel_valid, sel_id, X_OBJETO, Y_OBJETO, LARGURA_OBJETO,
               ALTURA_OBJETO, MULTPLICADOR, upd.upd_ack, frame_commit, coll_act};
      n_checks++;
      if (act_v[PACK_W-1:N_SPRITES+2] !== exp_v[PACK_W-1:N_SPRITES+2]) begin
        n_fail++;
        $display("FAIL sel @%0t X=%0d Y=%0d: got %h expected %h", $time, X_VGA, Y_VGA,
                 act_v[PACK_W-1:N_SPRITES+2], exp_v[PACK_W-1:N_SPRITES+2]);
      end
      n_checks++;
      if (act_v[N_SPRITES+1] !== exp_v[N_SPRITES+1]) begin
        n_fail++;
        $display("FAIL upd_ack @%0t: got %b expected %b", $time,
                 act_v[N_SPRITES+1], exp_v[N_SPRITES+1]);
      end
      n_checks++;
      if (act_v[N_SPRITES] !== exp_v[N_SPRITES]) begin
        n_fail++;
        $display("FAIL frame_commit @%0t: got %b expected %b", $time,
                 act_v[N_SPRITES], exp_v[N_SPRITES]);
      end
`ifdef SPRITE_SCHED_COLLISION_EN
      n_checks++;
      if (act_v[N_SPRITES-1:0] !== exp_v[N_SPRITES-1:0]) begin
        n_fail++;
        $display("FAIL collision_mask @%0t: got %b expected %b", $time,
                 act_v[N_SPRITES-1:0], exp_v[N_SPRITES-1:0]);
      end
`endif
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    reset = 1'b0;
    X_VGA = '0;
    Y_VGA = 10'd5;
    post_write(0, 0, 0, 0, 0, 0, 0);
    upd.upd_req = 1'b0;
    model_clear();
    repeat (2) @(posedge CLK);
    #2;
    reset = 1'b1;
    step(7, 7);

    // Reset pulse in the middle of a frame wipes everything back to blanking.
    frame_start();
    write_slot(0, 2, 2, 5, 5, 1, 1);
    frame_end();
    frame_start();
    scan(3, 1, 4);
    reset = 1'b0;
    repeat (3) step(3, 3);
    reset = 1'b1;
    n_checks++;
    if (state_dbg !== ST_BLANK) begin
      n_fail++;
      $display("FAIL state_after_reset: got %0d expected %0d", state_dbg, ST_BLANK);
    end
    scan(3, 1, 6);

    // Single sprite: committed at blanking, visible the following frame.
    frame_start();
    write_slot(0, 100, 50, 20, 10, 2, 1);
    scan(30, 1, 3);
    frame_end();
    frame_start();
    scan(50, 95, 145);
    scan(69, 98, 101);
    scan(70, 98, 101);
    scan(49, 99, 101);
    frame_end();

    // Overlapping slots 1 and 2: slot 1 wins, both flagged as colliding.
    frame_start();
    write_slot(1, 190, 190, 20, 20, 1, 1);
    write_slot(2, 195, 195, 10, 10, 2, 1);
    frame_end();
    frame_start();
    scan(200, 185, 215);
    frame_end();
    frame_start();
    scan(5, 1, 3);
    frame_end();

    // Request held across the commit cycle: accepted in blanking, shown a frame later.
    frame_start();
    scan(10, 1, 2);
    step(0, V_ACTIVE);
    write_slot(3, 300, 300, 10, 10, 1, 1);
    step(4, V_ACTIVE + 3);
    frame_start();
    scan(305, 295, 312);
    frame_end();
    frame_start();
    scan(305, 295, 312);
    write_slot(3, 300, 300, 10, 10, 0, 1);
    frame_end();
    frame_start();
    scan(305, 298, 302);
    write_slot(3, 1000, 300, 40, 2, 15, 1);
    frame_end();

    // Sprite near the right edge: scaled extent passes 1023 without wrapping.
    frame_start();
    scan(300, 995, 1023);
    scan(329, 1020, 1023);
    scan(330, 1020, 1023);
    frame_end();

    // Randomised frames: random descriptor writes interleaved with random pixels.
    for (int f = 0; f < 6; f++) begin
      frame_start();
      for (int k = 0; k < 60; k++) begin
        if (!upd.upd_req && $urandom_range(0, 5) == 0)
          post_write($urandom_range(0, N_SPRITES - 1), $urandom_range(0, 300),
                     $urandom_range(0, 300), $urandom_range(0, 40),
                     $urandom_range(0, 40), $urandom_range(0, 4),
                     $urandom_range(0, 3) != 0 ? 1 : 0);
        step($urandom_range(1, 400), $urandom_range(0, 400));
      end
      frame_end();
    end

    repeat (3) step(2, V_ACTIVE + 5);
    @(negedge CLK);
    #1;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/sprite_scheduler.md
Name: sprite_scheduler

Overview:
Per-frame controller that shares the single sprite buffer renderer between N sprite requesters. Game logic writes sprite descriptors (position, size, multiplier, visible) into shadow registers over a req/ack handshake. These are committed atomically to active registers at the start of vertical blanking, so there is no tearing. On every pixel the block arbitrates which active sprite owns the pixel by fixed priority and drives the renderer's object inputs plus a sprite select.

Parameters:
N_SPRITES, 4, number of sprite slots; ID width is clog2(N_SPRITES), minimum 1.
V_ACTIVE, 480, first Y_VGA value of vertical blanking.
COORD_W, 10, coordinate and size width.

Ports:
CLK  in  1  system/pixel clock
reset  in  1  synchronous, active-low; asserted when 0, sampled on CLK rising edge
X_VGA  in  10  pixel X, already offset to the active region
Y_VGA  in  10  pixel Y, already offset to the active region
upd_req  in  1  descriptor write request
upd_ack  out  1  write accepted this cycle (combinational from upd_req and state)
upd_id  in  ID_W  target slot
upd_x, upd_y  in  10 each  sprite origin
upd_w, upd_h  in  10 each  sprite width/height in source pixels
upd_mult  in  4  scale factor
upd_vis  in  1  visible flag
X_OBJETO, Y_OBJETO, LARGURA_OBJETO, ALTURA_OBJETO  out  10 each  winning sprite descriptor, to the renderer
MULTPLICADOR  out  4  winning sprite multiplier
sel_id  out  ID_W  winning slot, selects the buffer source
sel_valid  out  1  some sprite covers the pixel
frame_commit  out  1  one-cycle pulse in the COMMIT state

Behaviour:
- FSM states: BLANK, RUN, COMMIT.
  - BLANK -> RUN when X_VGA==0 and Y_VGA==0.
  - RUN -> COMMIT when X_VGA==0 and Y_VGA==V_ACTIVE.
  - COMMIT -> BLANK unconditionally after 1 cycle.
- Reset: state=BLANK; all shadow and active slots cleared (vis=0, fields 0); all outputs 0; upd_ack=0 while reset is low. A reset mid-frame therefore blanks all sprites until the next commit after new writes.
- Handshake:
  - upd_ack = upd_req when state is RUN or BLANK; forced to 0 in COMMIT.
  - An acked write lands in shadow[upd_id] on that edge.
  - Requesters hold req and fields stable until ack.
  - upd_id >= N_SPRITES is acked and discarded.
- COMMIT: active[i] <= shadow[i] for all i in the same edge; frame_commit=1 for exactly that cycle. A write acked in RUN the cycle before COMMIT is included in the commit.
- Hit test per slot i, using active values:
  - vis && mult!=0 && w!=0 && h!=0 && x <= X_VGA < x + w*mult && y <= Y_VGA < y + h*mult.
  - Products computed at 14 bits; sums at 15 bits, so there is no wrap.
  - Bounds are half-open: a sprite exactly at the right edge does not cover X = x + w*mult.
- Arbitration: lowest index hit wins (slot 0 has top priority).
- Outputs are registered with 1-cycle latency: the values at edge k reflect X_VGA/Y_VGA sampled at edge k. With no hit, sel_valid=0 and the descriptor outputs hold 0.
- Hit test is gated to state RUN; in BLANK and COMMIT, sel_valid=0.

Optional Feature:
SPRITE_SCHED_COLLISION_EN
- Defined:
  - Adds output collision_mask [N_SPRITES-1:0].
  - An internal sticky mask sets bit i whenever slot i hits on a pixel where at least one other slot also hits.
  - At COMMIT, collision_mask <= sticky and sticky is cleared; collision_mask otherwise holds until the next COMMIT.
  - Reset clears both.
- Undefined: the port is absent and there is no logic.

Decomposition:
- Package sprite_sched_pkg holds:
  - the descriptor struct (x, y, w, h, mult, vis);
  - the state enum;
  - ID_W as clog2(N_SPRITES);
  - COORD_W.
- Sub-module sprite_hit_test holds one slot's comparator (descriptor + X/Y -> hit). It is instantiated N_SPRITES times via generate.

Test Plan:
- Reset low for 3 cycles mid-RUN -> all outputs 0, upd_ack=0; after release, state=BLANK and sel_valid=0 for the whole frame.
- Write slot 0 (x=100, y=50, w=20, h=10, mult=2, vis=1) during RUN; no further writes; advance to Y_VGA=480, X_VGA=0 -> frame_commit pulses once.
  - Next frame, X=100..139 on Y=50 gives sel_valid=1, sel_id=0, X_OBJETO=100, one cycle after the pixel.
  - X=140 gives sel_valid=0.
- Slots 1 and 2 overlap at (200,200) -> sel_id=1. With COLLISION_EN, collision_mask=3'b110 after the next commit.
- upd_req held high across the COMMIT cycle -> upd_ack=0 in COMMIT, 1 in the following cycle; data lands in shadow and appears the frame after.
- Write slot 3 with mult=0, vis=1 -> never hits. Write with upd_id=5 (N_SPRITES=4) -> acked, no slot changes.
- Slot at x=1000, w=40, mult=15 -> no overflow; hit covers X=1000..1023 only.
